aes_word_ctrl: RTL

Sequencing controller between a 32-bit word stream and a 128-bit AES core with fixed latency.
- Deserialises key and plaintext words, pulses the core start, and waits exactly LATENCY cycles.
- Captures the 128-bit result and serialises it as four 32-bit words with valid/ready backpressure.
- Sits between the bus-side word agent and the AES datapath; owns all core handshaking.

---
 rtl/aes_word_ctrl_pkg.sv | 20 ++
 rtl/aes_word_ser.sv | 45 ++++
 rtl/aes_word_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_word_ctrl_pkg.sv
// Shared AES sequencing definitions: core latency default, block geometry, controller states
// and the FIPS-197 appendix C.1 reference vector.
package aes_word_ctrl_pkg;

    localparam int LATENCY_DEF   = 2;
    localparam int WORDS_PER_BLK = 4;
    localparam int KEY_WORDS     = 4;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DRAIN
    } aes_ctrl_state_e;

    localparam logic [127:0] NIST_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NIST_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] NIST_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_word_ser.sv
// Result serialiser: holds one AES block and emits it most-significant word first.
// Latency: first word valid the cycle after load.
// Backpressure: the word index advances only on out_vld && out_rdy; data/last hold otherwise.
module aes_word_ser
    import aes_word_ctrl_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 4 * WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_dat,
    output logic              out_last,
    output logic              done
);

    logic [BLK_W-1:0] hold;
    logic [1:0]       idx;

    assign out_dat  = hold[WORD_W*(WORDS_PER_BLK-1-int'(idx)) +: WORD_W];
    assign out_last = out_vld && (idx == 2'(WORDS_PER_BLK-1));
    assign done     = out_last && out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            idx     <= 2'd0;
            out_vld <= 1'b0;
        end else if (load) begin
            hold    <= load_dat;
            idx     <= 2'd0;
            out_vld <= 1'b1;
        end else if (out_vld && out_rdy) begin
            idx <= idx + 2'd1;
            if (done) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_word_ctrl.sv
// Word-stream to fixed-latency AES core sequencer: deserialise key/plaintext, start, capture, drain.
// Latency: start the cycle after the last input word; first output word LATENCY+1 cycles after start.
// Backpressure: input stalls (in_ready=0) from start until the last output word is accepted.
module aes_word_ctrl
    import aes_word_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int WORD_W  = 32,
    parameter int BLK_W   = 4 * WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              reuse_key,
    output logic [BLK_W-1:0]  core_key,
    output logic [BLK_W-1:0]  core_data,
    output logic              core_start,
    input  logic [BLK_W-1:0]  core_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       blk_cnt
);

    aes_ctrl_state_e state;
    logic [2:0]      widx;
    logic [3:0]      wait_cnt;
    logic            key_loaded;
    logic            reuse_r;
    logic            in_acc;
    logic            reuse_now;
    logic [2:0]      slot;
    logic [1:0]      lane;
    logic            last_word;
    logic            ser_load;
    logic            ser_done;

    // A reuse block is mapped onto the plaintext half of the slot space so one index covers both.
    assign in_acc    = in_valid && in_ready;
    assign reuse_now = (widx == 3'd0) ? (reuse_key && key_loaded) : reuse_r;
    assign slot      = reuse_now ? (widx + 3'(KEY_WORDS)) : widx;
    assign lane      = slot[1:0];
    assign last_word = (slot == 3'(KEY_WORDS + WORDS_PER_BLK - 1));
    assign ser_load  = (state == WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            widx       <= 3'd0;
            wait_cnt   <= 4'd0;
            key_loaded <= 1'b0;
            reuse_r    <= 1'b0;
            in_ready   <= 1'b1;
            core_key   <= '0;
            core_data  <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            blk_cnt    <= 16'd0;
        end else begin
            core_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        reuse_r <= reuse_now;
                        if (slot < 3'(KEY_WORDS)) begin
                            core_key[WORD_W*(WORDS_PER_BLK-1-int'(lane)) +: WORD_W] <= in_data;
                        end else begin
                            core_data[WORD_W*(WORDS_PER_BLK-1-int'(lane)) +: WORD_W] <= in_data;
                        end
                        if (last_word) begin
                            widx       <= 3'd0;
                            state      <= START;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                            core_start <= 1'b1;
                            if (!reuse_now) begin
                                key_loaded <= 1'b1;
                            end
                        end else begin
                            widx <= widx + 3'd1;
                        end
                    end
                end
                START: begin
                    wait_cnt <= 4'(LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (ser_done) begin
                        blk_cnt  <= blk_cnt + 16'd1;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    aes_word_ser #(
        .WORD_W (WORD_W),
        .BLK_W  (BLK_W)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .load_dat (core_out),
        .out_vld  (out_valid),
        .out_rdy  (out_ready),
        .out_dat  (out_data),
        .out_last (out_last),
        .done     (ser_done)
    );

endmodule
